// File: rtl/sram_bist.sv
// Built-in self-test for the DE0-Nano SRAM user interface: a write pass of a
// selectable pattern over 0..LAST_ADDR, then a read-back and compare pass.
module sram_bist #(
    parameter int                 ADDR_W    = 19,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(19'h7FFFF),
    parameter int                 WE_CYCLES = 2,
    parameter int                 RD_WAIT   = 2
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SET   = 3'd1,
        S_WR_PULSE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_RD_SET   = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_RD_CMP   = 3'd6,
        S_FIN      = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_cnt;
    logic [1:0]        r_pat;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_err_cnt;
    logic [ADDR_W-1:0] r_first_addr;
    logic [DATA_W-1:0] r_first_data;
    logic              r_mem_we;
    logic              w_accept;
    logic              w_last;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_expect;

    function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0] sel,
                                                      input logic [ADDR_W-1:0] a);
        logic [15:0] one;
        logic [15:0] p;
        one = 16'h0001;
        case (sel)
            2'd0:    p = a[15:0];
            2'd1:    p = ~a[15:0];
            2'd2:    p = a[0] ? 16'hAAAA : 16'h5555;
            default: p = one << a[3:0];
        endcase
        return DATA_W'(p);
    endfunction

    assign w_expect   = pattern_of(r_pat, r_addr);
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_mismatch = (mem_rdata != w_expect);
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_FIN));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FIN: if (start) w_next = S_WR_SET;
            S_WR_SET:      w_next = S_WR_PULSE;
            S_WR_PULSE:    if (r_cnt == 16'(WE_CYCLES - 1)) w_next = S_WR_HOLD;
            S_WR_HOLD:     w_next = w_last ? S_RD_SET : S_WR_SET;
            S_RD_SET:      w_next = (RD_WAIT > 1) ? S_RD_WAIT : S_RD_CMP;
            S_RD_WAIT:     if (r_cnt == 16'(RD_WAIT - 2)) w_next = S_RD_CMP;
            S_RD_CMP:      w_next = w_last ? S_FIN : S_RD_SET;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pat        <= '0;
            r_addr       <= '0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_state  <= w_next;
            // Per-state dwell counter restarts whenever the state changes.
            r_cnt    <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_mem_we <= (w_next == S_WR_PULSE);
            if (w_accept) begin
                r_pat        <= pattern_sel;
                r_addr       <= '0;
                r_err_cnt    <= '0;
                r_first_addr <= '0;
                r_first_data <= '0;
            end else if (r_state == S_WR_HOLD) begin
                r_addr <= w_last ? '0 : r_addr + 1'b1;
            end else if (r_state == S_RD_CMP) begin
                if (!w_last) r_addr <= r_addr + 1'b1;
                if (w_mismatch) begin
                    if (r_err_cnt == 16'd0) begin
                        r_first_addr <= r_addr;
                        r_first_data <= mem_rdata;
                    end
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign busy           = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done           = (r_state == S_FIN);
    assign pass           = done && (r_err_cnt == 16'd0);
    assign err_count      = r_err_cnt;
    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;
    assign mem_addr       = r_addr;
    assign mem_wdata      = w_expect;
    assign mem_we         = r_mem_we;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist on a 16-word behavioural SRAM with ideal,
// stuck-bit and constant-data read faults.
module tb_sram_bist;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        busy, done, pass, mem_we;
    logic [15:0] err_count;
    logic [18:0] first_err_addr, mem_addr;
    logic [15:0] first_err_data, mem_wdata, mem_rdata;
    logic [2:0]  o_dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc;
    int mode = 0;
    logic clr_mem = 1'b0;
    logic [15:0] mem [16];
    logic [15:0] rd;

    always #10 CLOCK_50 = ~CLOCK_50;

    sram_bist #(
        .ADDR_W(19), .DATA_W(16), .LAST_ADDR(19'd15), .WE_CYCLES(2), .RD_WAIT(2)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .pattern_sel(pattern_sel),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .o_dbg_state(o_dbg_state)
    );

    // SRAM model: mode 0 ideal, 1 data bit 3 stuck at 0, 2 always reads DEAD.
    always @(posedge CLOCK_50) begin
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hBEEF;
        end else if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    always_comb begin
        rd = mem[mem_addr[3:0]];
        mem_rdata = rd;
        if (mode == 1) mem_rdata = rd & 16'hFFF7;
        else if (mode == 2) mem_rdata = 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pat(input logic [1:0] p, input int a);
        logic [15:0] av;
        av = 16'(a);
        case (p)
            2'd0:    return av;
            2'd1:    return ~av;
            2'd2:    return av[0] ? 16'hAAAA : 16'h5555;
            default: return 16'h0001 << av[3:0];
        endcase
    endfunction

    task automatic clear_mem();
        @(negedge CLOCK_50) clr_mem = 1'b1;
        @(negedge CLOCK_50) clr_mem = 1'b0;
    endtask

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic start_run(input logic [1:0] p);
        @(negedge CLOCK_50);
        pattern_sel = p;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Counts clock edges after the accepting edge until done is seen.
    task automatic wait_done(input bit spam, output int n);
        n = 0;
        while (!done && n < 1000) begin
            start = spam && (n == 10 || n == 50 || n == 100);
            if (spam) pattern_sel = 2'd1;
            @(negedge CLOCK_50);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [1:0] p);
        for (int a = 0; a < 16; a++) check(tag, {16'd0, mem[a]}, {16'd0, exp_pat(p, a)});
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_state", o_dbg_state, 0);
        rst = 1'b0;

        // Pattern 0, ideal memory: 112 cycles to done, clean pass
        clear_mem();
        start_run(2'd0);
        check("p0_busy_start", busy, 1);
        check("p0_done_start", done, 0);
        wait_done(1'b0, cyc);
        check("p0_latency", cyc, 112);
        check("p0_pass", pass, 1);
        check("p0_err", err_count, 0);
        check("p0_busy_fin", busy, 0);
        check_mem("p0_mem", 2'd0);

        // Pattern 1, 2, 3 on ideal memory
        clear_mem();
        start_run(2'd1);
        wait_done(1'b0, cyc);
        check("p1_pass", pass, 1);
        check_mem("p1_mem", 2'd1);

        clear_mem();
        start_run(2'd2);
        wait_done(1'b0, cyc);
        check("p2_pass", pass, 1);
        check("p2_mem0", mem[0], 16'h5555);
        check("p2_mem1", mem[1], 16'hAAAA);
        check_mem("p2_mem", 2'd2);

        clear_mem();
        start_run(2'd3);
        wait_done(1'b0, cyc);
        check("p3_pass", pass, 1);
        check("p3_mem9", mem[9], 16'h0200);
        check("p3_mem15", mem[15], 16'h8000);

        // Data bit 3 stuck low: addresses 8..15 fail
        mode = 1;
        clear_mem();
        start_run(2'd0);
        wait_done(1'b0, cyc);
        check("stuck_latency", cyc, 112);
        check("stuck_err", err_count, 8);
        check("stuck_faddr", first_err_addr, 8);
        check("stuck_fdata", first_err_data, 16'h0000);
        check("stuck_pass", pass, 0);
        check("stuck_done", done, 1);

        // Start from FIN clears results; starts while busy are ignored
        mode = 0;
        start_run(2'd0);
        check("refin_err_clr", err_count, 0);
        check("refin_faddr_clr", first_err_addr, 0);
        check("refin_done_clr", done, 0);
        check("refin_busy", busy, 1);
        wait_done(1'b1, cyc);
        check("spam_latency", cyc, 112);
        check("spam_pass", pass, 1);
        check_mem("spam_mem", 2'd0);

        // Reset during a write pulse abandons the test
        start_run(2'd1);
        @(negedge CLOCK_50);
        check("abort_we_pulse", mem_we, 1);
        check("abort_wdata", mem_wdata, 16'hFFFF);
        rst = 1'b1;
        @(negedge CLOCK_50);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata0", mem_wdata, 0);
        check("abort_state", o_dbg_state, 0);
        rst = 1'b0;
        clear_mem();
        start_run(2'd0);
        wait_done(1'b0, cyc);
        check("after_abort_latency", cyc, 112);
        check("after_abort_pass", pass, 1);

        // Every read returns DEAD; counter is pushed near the top to show saturation
        mode = 2;
        start_run(2'd0);
        cyc = 0;
        while (err_count == 16'd0 && cyc < 1000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check("dead_first_err_seen", err_count, 1);
        force dut.r_err_cnt = 16'hFFFA;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        release dut.r_err_cnt;
        wait_done(1'b0, cyc);
        check("dead_done", done, 1);
        check("dead_err_sat", err_count, 16'hFFFF);
        check("dead_faddr", first_err_addr, 0);
        check("dead_fdata", first_err_data, 16'hDEAD);
        check("dead_pass", pass, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
